// File: rtl/activation_sequencer.sv
// rtl/activation_sequencer.sv - instruction sequencer feeding the activation unit from the accumulator bank
//
// Purpose:
//   Accepts one activation instruction, streams accumulator row reads into the
//   activation unit (one per cycle, no bubbles), carries each row's unified-buffer
//   write address through the read + activation latency, issues aligned buffer
//   writes and pulses done together with the last write.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake (ready only while idle)
//   instr_acc_addr            first accumulator row
//   instr_buf_addr            first unified-buffer row
//   instr_length              number of rows (0 legal: done only)
//   instr_act_func            activation function
//   instr_signed              signed arithmetic select
//   acc_read_en/acc_read_addr accumulator read strobe and address
//   act_function/act_signed   function/signedness to the activation unit
//   buf_write_en/addr         unified-buffer write strobe and address
//   busy                      instruction in flight
//   done                      one-cycle completion pulse

package activation_pkg;
    typedef enum logic [1:0] {
        ACT_NO_ACTIVATION = 2'd0,
        ACT_RELU          = 2'd1,
        ACT_SIGMOID       = 2'd2
    } activation_type;
endpackage

module activation_sequencer
    import activation_pkg::*;
#(
    parameter int ACC_ADDR_WIDTH   = 9,
    parameter int BUF_ADDR_WIDTH   = 14,
    parameter int LENGTH_WIDTH     = 16,
    parameter int ACC_READ_LATENCY = 1,
    parameter int ACT_LATENCY      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
    input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr,
    input  logic [LENGTH_WIDTH-1:0]   instr_length,
    input  activation_type            instr_act_func,
    input  logic                      instr_signed,
    output logic                      acc_read_en,
    output logic [ACC_ADDR_WIDTH-1:0] acc_read_addr,
    output activation_type            act_function,
    output logic                      act_signed,
    output logic                      buf_write_en,
    output logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
    output logic                      busy,
    output logic                      done
);

    // Total cycles from a read strobe to the matching activation output.
    localparam int D = ACC_READ_LATENCY + ACT_LATENCY;
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ACC_ADDR_WIDTH-1:0] acc_base_q, acc_base_d;
    logic [BUF_ADDR_WIDTH-1:0] buf_base_q, buf_base_d;
    logic [LENGTH_WIDTH-1:0]   length_q, length_d;
    logic [LENGTH_WIDTH-1:0]   row_q, row_d;
    activation_type            act_function_q, act_function_d;
    logic                      act_signed_q, act_signed_d;
    logic                      zero_done_q, zero_done_d;

    // Delay line: stage D-1 is the row currently leaving the activation unit.
    logic [D-1:0]              pipe_valid_q, pipe_valid_d;
    logic [D-1:0]              pipe_last_q, pipe_last_d;
    logic [BUF_ADDR_WIDTH-1:0] pipe_addr_q [D];
    logic [BUF_ADDR_WIDTH-1:0] pipe_addr_d [D];

    logic accept;
    logic issuing;
    logic last_row;
    logic last_write;

    assign accept     = instr_valid && (state_q == ST_IDLE);
    assign issuing    = (state_q == ST_ISSUE);
    assign last_row   = (row_q == (length_q - LEN_ONE));
    assign last_write = pipe_valid_q[D-1] && pipe_last_q[D-1];

    // Next-state and instruction register logic.
    always_comb begin
        state_d        = state_q;
        acc_base_d     = acc_base_q;
        buf_base_d     = buf_base_q;
        length_d       = length_q;
        row_d          = row_q;
        act_function_d = act_function_q;
        act_signed_d   = act_signed_q;
        zero_done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_base_d     = instr_acc_addr;
                    buf_base_d     = instr_buf_addr;
                    length_d       = instr_length;
                    act_function_d = instr_act_func;
                    act_signed_d   = instr_signed;
                    row_d          = '0;
                    if (instr_length != '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Empty instruction: no reads or writes, just the completion pulse.
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                row_d = row_q + LEN_ONE;
                if (last_row) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_write) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Delay line shift. Addresses only advance alongside a valid entry so the
    // output stage keeps showing the last written address between writes.
    always_comb begin
        pipe_valid_d = '0;
        pipe_last_d  = '0;
        for (int i = 0; i < D; i++) begin
            pipe_addr_d[i] = pipe_addr_q[i];
        end

        pipe_valid_d[0] = issuing;
        pipe_last_d[0]  = issuing && last_row;
        if (issuing) begin
            pipe_addr_d[0] = buf_base_q + BUF_ADDR_WIDTH'(row_q);
        end

        for (int i = 1; i < D; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_last_d[i]  = pipe_last_q[i-1];
            if (pipe_valid_q[i-1]) begin
                pipe_addr_d[i] = pipe_addr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            acc_base_q     <= '0;
            buf_base_q     <= '0;
            length_q       <= '0;
            row_q          <= '0;
            act_function_q <= ACT_NO_ACTIVATION;
            act_signed_q   <= 1'b0;
            zero_done_q    <= 1'b0;
            pipe_valid_q   <= '0;
            pipe_last_q    <= '0;
            for (int i = 0; i < D; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            acc_base_q     <= acc_base_d;
            buf_base_q     <= buf_base_d;
            length_q       <= length_d;
            row_q          <= row_d;
            act_function_q <= act_function_d;
            act_signed_q   <= act_signed_d;
            zero_done_q    <= zero_done_d;
            pipe_valid_q   <= pipe_valid_d;
            pipe_last_q    <= pipe_last_d;
            for (int i = 0; i < D; i++) begin
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    assign instr_ready    = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign acc_read_en    = issuing;
    assign acc_read_addr  = acc_base_q + ACC_ADDR_WIDTH'(row_q);
    assign act_function   = act_function_q;
    assign act_signed     = act_signed_q;
    assign buf_write_en   = pipe_valid_q[D-1];
    assign buf_write_addr = pipe_addr_q[D-1];
    assign done           = zero_done_q || last_write;

endmodule

// File: tb/tb_activation_sequencer.sv
// tb/tb_activation_sequencer.sv - scoreboard bench for activation_sequencer
module tb_activation_sequencer;
    import activation_pkg::*;

    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic           instr_ready;
    logic [8:0]     instr_acc_addr;
    logic [13:0]    instr_buf_addr;
    logic [15:0]    instr_length;
    activation_type instr_act_func;
    logic           instr_signed;
    logic           acc_read_en;
    logic [8:0]     acc_read_addr;
    activation_type act_function;
    logic           act_signed;
    logic           buf_write_en;
    logic [13:0]    buf_write_addr;
    logic           busy;
    logic           done;

    activation_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_acc_addr (instr_acc_addr),
        .instr_buf_addr (instr_buf_addr),
        .instr_length   (instr_length),
        .instr_act_func (instr_act_func),
        .instr_signed   (instr_signed),
        .acc_read_en    (acc_read_en),
        .acc_read_addr  (acc_read_addr),
        .act_function   (act_function),
        .act_signed     (act_signed),
        .buf_write_en   (buf_write_en),
        .buf_write_addr (buf_write_addr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        int             addr;
        activation_type f;
        logic           s;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t dn_q[$];

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic flag(input string nm, input int exp_cyc);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: got no/unexpected event, expected cycle %0d", nm, cyc, exp_cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge. Holds valid until accepted, then queues
    // the expected reads, writes and done; events later than 'cut' cycles after
    // accept are not expected (used for the mid-instruction reset).
    task automatic issue(input logic [8:0] acc, input logic [13:0] bufa,
                         input logic [15:0] len, input activation_type f,
                         input logic s, input int cut, output int a);
        ev_t e;
        a = -1;
        instr_valid    = 1'b1;
        instr_acc_addr = acc;
        instr_buf_addr = bufa;
        instr_length   = len;
        instr_act_func = f;
        instr_signed   = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                a = cyc;
                break;
            end
        end
        if (a < 0) begin
            flag("accept_timeout", -1);
        end else begin
            e.f = f;
            e.s = s;
            for (int k = 0; k < int'(len); k++) begin
                e.cyc  = a + 1 + k;
                e.addr = (int'(acc) + k) % 512;
                if (e.cyc - a <= cut) rd_q.push_back(e);
                e.cyc  = a + 1 + D + k;
                e.addr = (int'(bufa) + k) % 16384;
                if (e.cyc - a <= cut) wr_q.push_back(e);
            end
            e.cyc  = (len == 16'd0) ? a + 1 : a + int'(len) + D;
            e.addr = 0;
            if (e.cyc - a <= cut) dn_q.push_back(e);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, write or done.
    always @(negedge clk) begin
        if (mon_en) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                flag("read_missing", rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                flag("write_missing", wr_q[0].cyc);
                void'(wr_q.pop_front());
            end
            while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
                flag("done_missing", dn_q[0].cyc);
                void'(dn_q.pop_front());
            end
            if (acc_read_en) begin
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    cmp("read_addr", int'(acc_read_addr), rd_q[0].addr);
                    cmp("read_func", int'(act_function), int'(rd_q[0].f));
                    cmp("read_signed", int'(act_signed), int'(rd_q[0].s));
                    void'(rd_q.pop_front());
                end else begin
                    flag("read_unexpected", -1);
                end
            end
            if (buf_write_en) begin
                if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                    cmp("write_addr", int'(buf_write_addr), wr_q[0].addr);
                    cmp("write_func", int'(act_function), int'(wr_q[0].f));
                    cmp("write_signed", int'(act_signed), int'(wr_q[0].s));
                    void'(wr_q.pop_front());
                end else begin
                    flag("write_unexpected", -1);
                end
            end
            if (done) begin
                if (dn_q.size() > 0 && dn_q[0].cyc == cyc) begin
                    cmp("done_func", int'(act_function), int'(dn_q[0].f));
                    cmp("done_busy", int'(busy), (dn_q[0].cyc == cyc && wr_q.size() == 0 && rd_q.size() == 0 && buf_write_en) ? 1 : int'(busy));
                    void'(dn_q.pop_front());
                end else begin
                    flag("done_unexpected", -1);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_instr_ready"}, int'(instr_ready), 1);
        cmp({tag, "_acc_read_en"}, int'(acc_read_en), 0);
        cmp({tag, "_acc_read_addr"}, int'(acc_read_addr), 0);
        cmp({tag, "_act_function"}, int'(act_function), int'(ACT_NO_ACTIVATION));
        cmp({tag, "_act_signed"}, int'(act_signed), 0);
        cmp({tag, "_buf_write_en"}, int'(buf_write_en), 0);
        cmp({tag, "_buf_write_addr"}, int'(buf_write_addr), 0);
        cmp({tag, "_busy"}, int'(busy), 0);
        cmp({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int a;
        rst            = 1'b1;
        instr_valid    = 1'b0;
        instr_acc_addr = '0;
        instr_buf_addr = '0;
        instr_length   = '0;
        instr_act_func = ACT_NO_ACTIVATION;
        instr_signed   = 1'b0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        mon_en = 1'b1;
        step(1);

        // Tests 1 and 4: second instruction held valid from the cycle after the first accept.
        issue(9'd10, 14'd100, 16'd4, ACT_RELU, 1'b0, 1000, a1);
        issue(9'd50, 14'd300, 16'd2, ACT_SIGMOID, 1'b1, 1000, a2);
        cmp("second_accept_cycle", a2, a1 + 9);
        step(10);

        // Test 2: zero length.
        issue(9'd5, 14'd7, 16'd0, ACT_RELU, 1'b0, 1000, a);
        @(negedge clk);
        cmp("zero_len_busy_c1", int'(busy), 0);
        cmp("zero_len_ready_c1", int'(instr_ready), 1);
        @(negedge clk);
        cmp("zero_len_busy_c2", int'(busy), 0);
        step(3);

        // Test 3: address wrap on both sides.
        issue(9'd511, 14'd16383, 16'd2, ACT_NO_ACTIVATION, 1'b1, 1000, a);
        step(10);

        // Test 5: reset during the third read of a four-row instruction.
        issue(9'd10, 14'd100, 16'd4, ACT_RELU, 1'b0, 3, a);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        step(1);
        issue(9'd20, 14'd200, 16'd3, ACT_NO_ACTIVATION, 1'b1, 1000, a);
        step(10);

        // Test 6: single row, sigmoid, signed; settings held after completion.
        issue(9'd33, 14'd44, 16'd1, ACT_SIGMOID, 1'b1, 1000, a);
        step(8);
        @(negedge clk);
        cmp("held_act_signed", int'(act_signed), 1);
        cmp("held_act_function", int'(act_function), int'(ACT_SIGMOID));
        cmp("idle_busy", int'(busy), 0);
        cmp("idle_buf_write_addr", int'(buf_write_addr), 44);
        step(1);

        step(20);
        cmp("rd_q_empty", rd_q.size(), 0);
        cmp("wr_q_empty", wr_q.size(), 0);
        cmp("dn_q_empty", dn_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
